pim_conv_bitserial: RTL and testbench

- Parametrised next-generation PIM convolution engine.
- Feeds an INPUT_SIZE-element, INPUT_P-bit unsigned feature vector into W_SLICES crossbar conv units, one bit-plane per cycle.
- Each ADC result is shift-and-added by bit position and weight-slice significance.
- Either one crossbar column (single mode) or all DEPTH columns (sweep mode) is processed per job; one result per column is returned over a valid/ready stream.

---
 rtl/pim_pkg.sv | 23 ++
 rtl/pim_conv_unit.sv | 42 ++++
 rtl/pim_shift_acc.sv | 40 ++++
 rtl/pim_conv_bitserial.sv | 132 +++++++++++++
 tb/tb_pim_conv_bitserial.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pim_pkg.sv
// Shared types and helpers for the bit-serial PIM convolution engine.
package pim_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPUTE = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_OUT     = 3'd3,
    ST_DONE    = 3'd4
  } pim_state_e;

  localparam logic PIM_MODE_SINGLE = 1'b0;
  localparam logic PIM_MODE_SWEEP  = 1'b1;

  // Ceiling log2 that never returns 0, so a single-entry range still gets a 1-bit index.
  function automatic int pim_clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/pim_conv_unit.sv
// One weight-slice crossbar: binary cell mask per column, popcount ADC with one-cycle latency.
module pim_conv_unit
  import pim_pkg::*;
#(
  parameter int INPUT_SIZE = 9,
  parameter int DEPTH      = 4,
  parameter int W_SLICES   = 2,
  parameter int SLICE      = 0,
  parameter int ADC_P      = 4,
  parameter int AW         = 2,
  parameter logic [DEPTH*W_SLICES*INPUT_SIZE-1:0] WEIGHTS = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_en,
  input  logic [AW-1:0]         i_addr,
  input  logic [INPUT_SIZE-1:0] i_bits,
  output logic [ADC_P-1:0]      o_adc
);
  localparam int PC_W = pim_clog2(INPUT_SIZE + 1);
  localparam int CW   = ((PC_W > ADC_P) ? PC_W : ADC_P) + 1;
  localparam logic [CW-1:0] ADC_MAX = CW'((1 << ADC_P) - 1);

  logic [INPUT_SIZE-1:0] w_hit;
  logic [CW-1:0]         w_cnt;
  logic [ADC_P-1:0]      r_adc;

  always_comb begin
    w_hit = i_bits & WEIGHTS[(int'(i_addr) * W_SLICES + SLICE) * INPUT_SIZE +: INPUT_SIZE];
    w_cnt = '0;
    for (int i = 0; i < INPUT_SIZE; i++) w_cnt = w_cnt + CW'(w_hit[i]);
  end

  // The ADC clips at full scale; an idle unit reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_adc <= '0;
    else if (i_en) r_adc <= (w_cnt > ADC_MAX) ? ADC_MAX[ADC_P-1:0] : w_cnt[ADC_P-1:0];
    else           r_adc <= '0;
  end

  assign o_adc = r_adc;
endmodule

// File: rtl/pim_shift_acc.sv
// Shift-and-add of all slice ADC results by bit position and slice significance, saturated output.
module pim_shift_acc #(
  parameter int W_SLICES = 2,
  parameter int WS_BITS  = 2,
  parameter int ADC_P    = 4,
  parameter int INPUT_P  = 8,
  parameter int OUT_P    = 16,
  parameter int BW       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_en,
  input  logic [BW-1:0]             i_bit,
  input  logic [W_SLICES*ADC_P-1:0] i_adc,
  output logic [OUT_P-1:0]          o_sat
);
  // Wide enough for the largest possible exact sum; kept wider than OUT_P so saturation is detectable.
  localparam int EXACT_W = ADC_P + INPUT_P + (W_SLICES - 1) * WS_BITS + 1;
  localparam int ACC_W   = (EXACT_W > OUT_P) ? EXACT_W : OUT_P + 1;
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({OUT_P{1'b1}});

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int s = 0; s < W_SLICES; s++) begin
      w_sum = w_sum + ((ACC_W'(i_adc[s*ADC_P +: ADC_P]) << i_bit) << (s * WS_BITS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_acc <= '0;
    else if (i_clear) r_acc <= '0;
    else if (i_en)    r_acc <= r_acc + w_sum;
  end

  assign o_sat = (r_acc > OUT_MAX) ? OUT_MAX[OUT_P-1:0] : r_acc[OUT_P-1:0];
endmodule

// File: rtl/pim_conv_bitserial.sv
// Bit-serial PIM convolution engine: job FSM, feature latch, bit-plane issue and result stream.
module pim_conv_bitserial
  import pim_pkg::*;
#(
  parameter int INPUT_SIZE = 9,
  parameter int INPUT_P    = 8,
  parameter int DEPTH      = 4,
  parameter int W_SLICES   = 2,
  parameter int WS_BITS    = 2,
  parameter int ADC_P      = 4,
  parameter int OUT_P      = 16,
  parameter logic [DEPTH*W_SLICES*INPUT_SIZE-1:0] WEIGHTS = '1,
  localparam int AW = pim_clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          ready,
  input  logic                          mode,
  input  logic [INPUT_SIZE*INPUT_P-1:0] Input_feature,
  input  logic [AW-1:0]                 Address,
  output logic [OUT_P-1:0]              Output,
  output logic [AW-1:0]                 out_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done_flag,
  output logic [2:0]                    o_dbg_state
);
  // Both streams use valid/ready: a transfer happens on a clock edge where both are high;
  // the producer holds its payload stable until then, and start is dropped (not queued) while busy.
  localparam int BW = pim_clog2(INPUT_P);
  localparam logic [BW-1:0] LAST_BIT = BW'(INPUT_P - 1);
  localparam logic [AW-1:0] LAST_COL = AW'(DEPTH - 1);

  pim_state_e r_state, w_next;
  logic [INPUT_SIZE*INPUT_P-1:0] r_feat;
  logic                          r_mode;
  logic [AW-1:0]                 r_col;
  logic [BW-1:0]                 r_bit;
  logic [BW-1:0]                 r_acc_bit;
  logic                          r_acc_en;
  logic w_accept_start, w_accept_out, w_issue, w_last_col, w_acc_clear;
  logic [AW-1:0]                 w_start_col;
  logic [INPUT_SIZE-1:0]         w_plane;
  logic [W_SLICES*ADC_P-1:0]     w_adc;

  assign w_accept_start = (r_state == ST_IDLE) && start;
  assign w_accept_out   = (r_state == ST_OUT) && out_ready;
  assign w_issue        = (r_state == ST_COMPUTE);
  assign w_last_col     = (r_mode == PIM_MODE_SINGLE) || (r_col == LAST_COL);
  assign w_acc_clear    = w_accept_start || (w_accept_out && !w_last_col);

  always_comb begin
    w_start_col = '0;
    if (mode == PIM_MODE_SINGLE) begin
      if ({1'b0, Address} > {1'b0, LAST_COL}) w_start_col = LAST_COL;
      else                                    w_start_col = Address;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_COMPUTE;
      ST_COMPUTE: if (r_bit == LAST_BIT) w_next = ST_DRAIN;
      ST_DRAIN:   w_next = ST_OUT;
      ST_OUT:     if (out_ready) w_next = w_last_col ? ST_DONE : ST_COMPUTE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Accumulation trails issue by one cycle to match the registered ADC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_feat    <= '0;
      r_mode    <= PIM_MODE_SINGLE;
      r_col     <= '0;
      r_bit     <= '0;
      r_acc_en  <= 1'b0;
      r_acc_bit <= '0;
    end else begin
      r_acc_en  <= w_issue;
      r_acc_bit <= r_bit;
      if (w_accept_start) begin
        r_feat <= Input_feature;
        r_mode <= mode;
        r_col  <= w_start_col;
        r_bit  <= '0;
      end else if (w_issue) begin
        r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
      end else if (w_accept_out && !w_last_col) begin
        r_col <= r_col + 1'b1;
        r_bit <= '0;
      end
    end
  end

  always_comb begin
    w_plane = '0;
    for (int i = 0; i < INPUT_SIZE; i++) w_plane[i] = r_feat[i*INPUT_P + int'(r_bit)];
  end

  for (genvar s = 0; s < W_SLICES; s++) begin : g_slice
    pim_conv_unit #(
      .INPUT_SIZE(INPUT_SIZE), .DEPTH(DEPTH), .W_SLICES(W_SLICES), .SLICE(s),
      .ADC_P(ADC_P), .AW(AW), .WEIGHTS(WEIGHTS)
    ) u_conv (
      .clk(clk), .rst_n(rst), .i_en(w_issue), .i_addr(r_col),
      .i_bits(w_plane), .o_adc(w_adc[s*ADC_P +: ADC_P])
    );
  end

  pim_shift_acc #(
    .W_SLICES(W_SLICES), .WS_BITS(WS_BITS), .ADC_P(ADC_P),
    .INPUT_P(INPUT_P), .OUT_P(OUT_P), .BW(BW)
  ) u_acc (
    .clk(clk), .rst_n(rst), .i_clear(w_acc_clear), .i_en(r_acc_en),
    .i_bit(r_acc_bit), .i_adc(w_adc), .o_sat(Output)
  );

  assign ready       = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_OUT);
  assign done_flag   = (r_state == ST_DONE);
  assign out_addr    = r_col;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_pim_conv_bitserial.sv
// Directed bench for pim_conv_bitserial: three lock-stepped instances with different weights / OUT_P.
module tb_pim_conv_bitserial;
  localparam int INPUT_SIZE = 9;
  localparam int INPUT_P    = 8;
  localparam int DEPTH      = 4;
  localparam int W_SLICES   = 2;
  localparam int AW         = 2;
  localparam int FW         = INPUT_SIZE * INPUT_P;
  // Column/slice masks, MSB first: {c3s1, c3s0, c2s1, c2s0, c1s1, c1s0, c0s1, c0s0}.
  localparam logic [DEPTH*W_SLICES*INPUT_SIZE-1:0] W_RAMP =
    {9'h000, 9'h1FF, 9'h000, 9'h03F, 9'h000, 9'h007, 9'h000, 9'h000};
  localparam logic [DEPTH*W_SLICES*INPUT_SIZE-1:0] W_FULL =
    {9'h000, 9'h000, 9'h000, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 9'h1FF};

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [FW-1:0] feat = '0;
  logic [AW-1:0] addr = '0;

  logic ready_a, valid_a, done_a, ready_b, valid_b, done_b, ready_c, valid_c, done_c;
  logic [15:0] out_a, out_b;
  logic [11:0] out_c;
  logic [AW-1:0] oaddr_a, oaddr_b, oaddr_c;
  logic [2:0] dbg_a, dbg_b, dbg_c;

  int n_checks = 0;
  int n_errors = 0;

  pim_conv_bitserial #(.OUT_P(16), .WEIGHTS(W_RAMP)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .ready(ready_a), .mode(mode),
    .Input_feature(feat), .Address(addr), .Output(out_a), .out_addr(oaddr_a),
    .out_valid(valid_a), .out_ready(out_ready), .done_flag(done_a), .o_dbg_state(dbg_a));

  pim_conv_bitserial #(.OUT_P(16), .WEIGHTS(W_FULL)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .ready(ready_b), .mode(mode),
    .Input_feature(feat), .Address(addr), .Output(out_b), .out_addr(oaddr_b),
    .out_valid(valid_b), .out_ready(out_ready), .done_flag(done_b), .o_dbg_state(dbg_b));

  pim_conv_bitserial #(.OUT_P(12), .WEIGHTS(W_FULL)) u_dut_c (
    .clk(clk), .rst(rst), .start(start), .ready(ready_c), .mode(mode),
    .Input_feature(feat), .Address(addr), .Output(out_c), .out_addr(oaddr_c),
    .out_valid(valid_c), .out_ready(out_ready), .done_flag(done_c), .o_dbg_state(dbg_c));

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a job for exactly one edge, then scrambles the inputs so the job must use its latch.
  task automatic start_job(input logic m, input logic [7:0] v, input logic [AW-1:0] a);
    mode  = m;
    feat  = {INPUT_SIZE{v}};
    addr  = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = ~m;
    feat  = ~feat;
    addr  = ~a;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!valid_a && n < budget) begin
      tick();
      n++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if ({ready_a, valid_a, done_a, out_a, oaddr_a, dbg_a} !== {1'b1, 1'b0, 1'b0, 16'd0, 2'd0, 3'd0}) begin
      n_errors++;
      $display("FAIL reset_a: got rdy=%b vld=%b done=%b out=%0d addr=%0d st=%0d, expected 1 0 0 0 0 0",
               ready_a, valid_a, done_a, out_a, oaddr_a, dbg_a);
    end
    n_checks++;
    if ({ready_c, valid_c, done_c, out_c, oaddr_c} !== {1'b1, 1'b0, 1'b0, 12'd0, 2'd0}) begin
      n_errors++;
      $display("FAIL reset_c: got rdy=%b vld=%b done=%b out=%0d addr=%0d, expected 1 0 0 0 0",
               ready_c, valid_c, done_c, out_c, oaddr_c);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_latency();
    int lat;
    out_ready = 1'b0;
    start_job(1'b0, 8'h01, 2'd0);
    lat = 1;
    while (!valid_a && lat < 30) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat !== 10) begin
      n_errors++;
      $display("FAIL single_latency: got out_valid after %0d cycles, expected 10", lat);
    end
    n_checks++;
    if ({out_b, oaddr_b, out_a, out_c} !== {16'd9, 2'd0, 16'd0, 12'd9}) begin
      n_errors++;
      $display("FAIL single_result: got b=%0d addr=%0d a=%0d c=%0d, expected 9 0 0 9",
               out_b, oaddr_b, out_a, out_c);
    end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({done_a, valid_a, ready_a} !== 3'b100) begin
      n_errors++;
      $display("FAIL single_done: got done=%b vld=%b rdy=%b, expected 1 0 0", done_a, valid_a, ready_a);
    end
    out_ready = 1'b0;
    tick();
    n_checks++;
    if ({done_a, ready_a} !== 2'b01) begin
      n_errors++;
      $display("FAIL single_idle: got done=%b rdy=%b, expected 0 1", done_a, ready_a);
    end
  endtask

  task automatic test_full_scale();
    int n;
    out_ready = 1'b0;
    start_job(1'b0, 8'hFF, 2'd1);
    wait_valid(30, n);
    n_checks++;
    if (valid_a !== 1'b1) begin
      n_errors++;
      $display("FAIL full_timeout: got out_valid=%b after %0d cycles, expected 1", valid_a, n);
    end
    n_checks++;
    if ({out_b, oaddr_b} !== {16'd11475, 2'd1}) begin
      n_errors++;
      $display("FAIL full_result: got %0d addr %0d, expected 11475 addr 1", out_b, oaddr_b);
    end
    n_checks++;
    if (out_c !== 12'd4095) begin
      n_errors++;
      $display("FAIL full_saturate: got %0d, expected 4095", out_c);
    end
    n_checks++;
    if (out_a !== 16'd765) begin
      n_errors++;
      $display("FAIL full_partial_col: got %0d, expected 765", out_a);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (ready_a !== 1'b1) begin
      n_errors++;
      $display("FAIL full_idle: got ready=%b, expected 1", ready_a);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] exp_q[$];
    logic [15:0] exp_b_q[$];
    logic [15:0] exp_v, exp_bv;
    int n_res, n_done, last_t;
    exp_q.push_back(16'd0); exp_q.push_back(16'd3); exp_q.push_back(16'd6); exp_q.push_back(16'd9);
    exp_b_q.push_back(16'd9); exp_b_q.push_back(16'd45); exp_b_q.push_back(16'd9); exp_b_q.push_back(16'd0);
    n_res = 0; n_done = 0; last_t = 0;
    out_ready = 1'b1;
    start_job(1'b1, 8'h01, 2'd3);
    for (int t = 1; t <= 80; t++) begin
      if (valid_a) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL sweep_extra: got result %0d at addr %0d, expected none", out_a, oaddr_a);
        end else begin
          exp_v  = exp_q.pop_front();
          exp_bv = exp_b_q.pop_front();
          if ({out_a, out_b, oaddr_a} !== {exp_v, exp_bv, 2'(n_res)}) begin
            n_errors++;
            $display("FAIL sweep_result: got a=%0d b=%0d addr=%0d, expected %0d %0d %0d",
                     out_a, out_b, oaddr_a, exp_v, exp_bv, n_res);
          end
          if (n_res > 0) begin
            n_checks++;
            if (t - last_t !== 10) begin
              n_errors++;
              $display("FAIL sweep_interval: got %0d cycles, expected 10", t - last_t);
            end
          end
          last_t = t;
          n_res++;
        end
      end
      if (done_a) begin
        n_done++;
        n_checks++;
        if (n_res !== 4) begin
          n_errors++;
          $display("FAIL sweep_done_order: got done after %0d results, expected 4", n_res);
        end
      end
      if (ready_a && n_done > 0) break;
      tick();
    end
    n_checks++;
    if ({n_res, n_done} !== {32'd4, 32'd1}) begin
      n_errors++;
      $display("FAIL sweep_counts: got %0d results %0d done, expected 4 1", n_res, n_done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    out_ready = 1'b0;
    start_job(1'b0, 8'h0F, 2'd2);
    wait_valid(30, n);
    n_checks++;
    if ({valid_a, out_a, out_b} !== {1'b1, 16'd90, 16'd135}) begin
      n_errors++;
      $display("FAIL stall_result: got vld=%b a=%0d b=%0d, expected 1 90 135", valid_a, out_a, out_b);
    end
    for (int k = 0; k < 20; k++) begin
      start = 1'b1;
      feat  = {INPUT_SIZE{8'(k)}};
      tick();
      n_checks++;
      if ({valid_a, out_a, oaddr_a, ready_a, dbg_a} !== {1'b1, 16'd90, 2'd2, 1'b0, 3'd3}) begin
        n_errors++;
        $display("FAIL stall_hold: cycle %0d got vld=%b out=%0d addr=%0d rdy=%b st=%0d, expected 1 90 2 0 3",
                 k, valid_a, out_a, oaddr_a, ready_a, dbg_a);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (done_a !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_done: got done=%b, expected 1", done_a);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      n_checks++;
      if ({valid_a, ready_a} !== 2'b01) begin
        n_errors++;
        $display("FAIL stall_no_queue: cycle %0d got vld=%b rdy=%b, expected 0 1", k, valid_a, ready_a);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    int seen, n;
    seen = 0;
    out_ready = 1'b1;
    start_job(1'b1, 8'h01, 2'd0);
    for (int k = 0; k < 60 && seen < 2; k++) begin
      tick();
      if (valid_a) seen++;
    end
    tick(); tick(); tick();
    n_checks++;
    if ({seen, dbg_a, oaddr_a} !== {32'd2, 3'd1, 2'd2}) begin
      n_errors++;
      $display("FAIL midjob_setup: got seen=%0d st=%0d col=%0d, expected 2 1 2", seen, dbg_a, oaddr_a);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ready_a, valid_a, dbg_a, out_a} !== {1'b1, 1'b0, 3'd0, 16'd0}) begin
      n_errors++;
      $display("FAIL midjob_reset: got rdy=%b vld=%b st=%0d out=%0d, expected 1 0 0 0",
               ready_a, valid_a, dbg_a, out_a);
    end
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    start_job(1'b0, 8'hFF, 2'd1);
    wait_valid(30, n);
    n_checks++;
    if ({valid_a, out_a, out_b, oaddr_a} !== {1'b1, 16'd765, 16'd11475, 2'd1}) begin
      n_errors++;
      $display("FAIL midjob_recover: got vld=%b a=%0d b=%0d addr=%0d, expected 1 765 11475 1",
               valid_a, out_a, out_b, oaddr_a);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_latency();
    test_full_scale();
    test_sweep();
    test_stall();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
